// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external, purely combinational ALU between two requesters.
// A three-state controller (IDLE -> EXEC -> RESP -> IDLE) grants one
// requester at a time with round-robin fairness. It latches that requester's
// operands and opcode, and drives them to the ALU from registers. It captures
// the ALU result and flags one cycle later, then strobes a one-cycle response
// back to the granted requester. This block does no arithmetic of its own, and
// it passes opcodes through unchecked.
//
// Timing of one operation (transfer at edge 0):
//   cycle before edge 0 : IDLE, req_ready[g] high combinationally
//   edge 0              : operands captured, state -> EXEC
//   edge 1              : alu_out / flags captured, state -> RESP
//   cycle after edge 1  : rsp_valid[g] high for exactly one cycle
//   edge 2              : state -> IDLE (one idle cycle before the next grant)
// Sustained throughput is therefore one operation every three cycles.
//
// Parameters
//   DATA_W     operand / result width
//
// Ports
//   clk        input   1         sole clock, rising edge
//   n_rst      input   1         synchronous, active-low reset
//   req_valid  input   2         request valid, bit i = requester i
//   req_a      input   2*DATA_W  port_A operands, requester i at [i*DATA_W +: DATA_W]
//   req_b      input   2*DATA_W  port_B operands, same packing
//   req_op     input   8         4-bit opcodes, requester i at [i*4 +: 4]
//   req_ready  output  2         accept strobe, at most one bit high, IDLE only
//   alu_a      output  DATA_W    ALU port_A (held from captured register)
//   alu_b      output  DATA_W    ALU port_B (held from captured register)
//   alu_op     output  4         ALU opcode (held from captured register)
//   alu_out    input   DATA_W    ALU result
//   alu_neg    input   1         ALU negative flag
//   alu_zero   input   1         ALU zero flag
//   alu_ovf    input   1         ALU overflow flag
//   rsp_valid  output  2         one-hot response strobe to the granted requester
//   rsp_data   output  DATA_W    registered ALU result, held until next capture
//   rsp_flags  output  3         registered {neg, zero, ovf}, held likewise
//   busy       output  1         high whenever the controller is not in IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic [1:0]            req_valid,
   input  logic [2*DATA_W-1:0]   req_a,
   input  logic [2*DATA_W-1:0]   req_b,
   input  logic [7:0]            req_op,
   output logic [1:0]            req_ready,
   output logic [DATA_W-1:0]     alu_a,
   output logic [DATA_W-1:0]     alu_b,
   output logic [3:0]            alu_op,
   input  logic [DATA_W-1:0]     alu_out,
   input  logic                  alu_neg,
   input  logic                  alu_zero,
   input  logic                  alu_ovf,
   output logic [1:0]            rsp_valid,
   output logic [DATA_W-1:0]     rsp_data,
   output logic [2:0]            rsp_flags,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Round-robin choice between two requesters. With both requesting, the one
   // not granted last time wins; with a single requester, it wins outright.
   // When nobody requests, the result is unused because no grant is issued.
   function automatic logic rr_pick(input logic [1:0] valid, input logic last);
      logic pick;
      case (valid)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
         default: pick = ~last;
      endcase
      return pick;
   endfunction

   function automatic logic [1:0] idx_to_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   // Registered state and next-state values
   state_t              state_q,     state_d;
   logic                last_q,      last_d;       // last granted requester
   logic                gnt_q,       gnt_d;        // requester owning the op
   logic [DATA_W-1:0]   a_q,         a_d;
   logic [DATA_W-1:0]   b_q,         b_d;
   logic [3:0]          op_q,        op_d;
   logic [1:0]          rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
   logic [2:0]          rsp_flags_q, rsp_flags_d;
   logic                busy_q,      busy_d;

   // Combinational arbitration
   logic                win_idx;
   logic                xfer;

   always_comb begin
      win_idx = rr_pick(req_valid, last_q);
      // A transfer is only offered in IDLE. Gating it with n_rst keeps
      // req_ready low while reset is asserted, so no requester sees an accept
      // that the reset edge would discard.
      xfer      = (state_q == ST_IDLE) && (req_valid != 2'b00) && n_rst;
      req_ready = xfer ? idx_to_onehot(win_idx) : 2'b00;
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gnt_d       = gnt_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      rsp_valid_d = 2'b00;            // response strobe lasts a single cycle
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;

      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               state_d = ST_EXEC;
               last_d  = win_idx;
               gnt_d   = win_idx;
               a_d     = win_idx ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
               b_d     = win_idx ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
               op_d    = win_idx ? req_op[7:4] : req_op[3:0];
            end
         end
         ST_EXEC: begin
            // The ALU has had a full cycle to settle on the held operands.
            rsp_data_d  = alu_out;
            rsp_flags_d = {alu_neg, alu_zero, alu_ovf};
            rsp_valid_d = idx_to_onehot(gnt_q);
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State register. Reset clears every output-visible register. It also sets
   // the last-grant pointer to requester 1, so requester 0 wins the first
   // contention. An operation in flight is abandoned without a response.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         gnt_q       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         rsp_valid_q <= 2'b00;
         rsp_data_q  <= '0;
         rsp_flags_q <= 3'b000;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
         busy_q      <= busy_d;
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_flags = rsp_flags_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   logic          clk;
   logic          n_rst;
   logic [1:0]    req_valid;
   logic [31:0]   a_r  [2];
   logic [31:0]   b_r  [2];
   logic [3:0]    op_r [2];
   logic [63:0]   req_a;
   logic [63:0]   req_b;
   logic [7:0]    req_op;
   logic [1:0]    req_ready;
   logic [31:0]   alu_a;
   logic [31:0]   alu_b;
   logic [3:0]    alu_op;
   logic [31:0]   alu_out;
   logic          stub_neg, stub_zero, stub_ovf;
   logic [1:0]    rsp_valid;
   logic [31:0]   rsp_data;
   logic [2:0]    rsp_flags;
   logic          busy;

   int tests = 0;
   int fails = 0;

   assign req_a  = {a_r[1], a_r[0]};
   assign req_b  = {b_r[1], b_r[0]};
   assign req_op = {op_r[1], op_r[0]};

   // Stand-in for the external ALU: any deterministic function of its inputs.
   function automatic logic [31:0] stub_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
      return (a + b) ^ {op, 28'h0} ^ {28'h0, op};
   endfunction

   always_comb alu_out = stub_alu(alu_a, alu_b, alu_op);

   alu_arbiter #(.DATA_W(32)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .req_ready (req_ready),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_out   (alu_out),
      .alu_neg   (stub_neg),
      .alu_zero  (stub_zero),
      .alu_ovf   (stub_ovf),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_flags (rsp_flags),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      n_rst     = 1'b0;
      req_valid = 2'b00;
      {stub_neg, stub_zero, stub_ovf} = 3'b000;
      tick();
      tick();
      n_rst = 1'b1;
   endtask

   task automatic test_reset();
      n_rst     = 1'b0;
      req_valid = 2'b11;
      for (int i = 0; i < 2; i++) begin
         a_r[i] = $urandom; b_r[i] = $urandom; op_r[i] = 4'($urandom);
      end
      tick();
      tick();
      tests++;
      if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
         fails++;
         $display("FAIL reset_ctrl: busy=%b rsp_valid=%b req_ready=%b, want 0/00/00",
                  busy, rsp_valid, req_ready);
      end
      tests++;
      if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 4'h0 ||
          rsp_data !== 32'h0 || rsp_flags !== 3'b000) begin
         fails++;
         $display("FAIL reset_data: alu_a=%h alu_b=%h alu_op=%h rsp_data=%h rsp_flags=%b, want all 0",
                  alu_a, alu_b, alu_op, rsp_data, rsp_flags);
      end
      n_rst = 1'b1;
      #1;
      tests++;
      if (req_ready !== 2'b01) begin
         fails++;
         $display("FAIL reset_first_contention: req_ready=%b want 01", req_ready);
      end
      req_valid = 2'b00;
   endtask

   task automatic test_single();
      logic [31:0] exp_d;
      apply_reset();
      a_r[0] = 32'h5555AAAA; b_r[0] = 32'h44442222; op_r[0] = 4'd4;
      a_r[1] = 32'hDEADBEEF; b_r[1] = 32'h01234567; op_r[1] = 4'hF;
      exp_d  = stub_alu(32'h5555AAAA, 32'h44442222, 4'd4);
      req_valid = 2'b01;
      #1;
      tests++;
      if (req_ready !== 2'b01) begin
         fails++; $display("FAIL single_ready: req_ready=%b want 01", req_ready);
      end
      tick();   // transfer edge
      tests++;
      if (alu_a !== 32'h5555AAAA || alu_b !== 32'h44442222 || alu_op !== 4'd4) begin
         fails++;
         $display("FAIL single_alu_drive: a=%h b=%h op=%h want 5555aaaa 44442222 4",
                  alu_a, alu_b, alu_op);
      end
      tests++;
      if (req_ready !== 2'b00 || busy !== 1'b1 || rsp_valid !== 2'b00) begin
         fails++;
         $display("FAIL single_exec: req_ready=%b busy=%b rsp_valid=%b want 00 1 00",
                  req_ready, busy, rsp_valid);
      end
      req_valid = 2'b00;
      tick();
      tests++;
      if (rsp_valid !== 2'b01 || rsp_data !== exp_d) begin
         fails++;
         $display("FAIL single_rsp: rsp_valid=%b rsp_data=%h want 01 %h", rsp_valid, rsp_data, exp_d);
      end
      tick();
      tests++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== exp_d || alu_a !== 32'h5555AAAA) begin
         fails++;
         $display("FAIL single_after: rsp_valid=%b busy=%b rsp_data=%h alu_a=%h want 00 0 %h 5555aaaa",
                  rsp_valid, busy, rsp_data, alu_a, exp_d);
      end
   endtask

   task automatic test_alternate();
      logic [1:0]  eg;
      logic [31:0] ea, exp_d;
      int          g;
      apply_reset();
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 2; i++) begin
            a_r[i] = $urandom; b_r[i] = $urandom; op_r[i] = 4'($urandom);
         end
         g     = k % 2;
         eg    = (g == 0) ? 2'b01 : 2'b10;
         ea    = a_r[g];
         exp_d = stub_alu(a_r[g], b_r[g], op_r[g]);
         #1;
         tests++;
         if (req_ready !== eg) begin
            fails++; $display("FAIL alt_grant[%0d]: req_ready=%b want %b", k, req_ready, eg);
         end
         tick();
         tests++;
         if (alu_a !== ea) begin
            fails++; $display("FAIL alt_alu_a[%0d]: alu_a=%h want %h", k, alu_a, ea);
         end
         tick();
         tests++;
         if (rsp_valid !== eg || rsp_data !== exp_d) begin
            fails++;
            $display("FAIL alt_rsp[%0d]: rsp_valid=%b rsp_data=%h want %b %h",
                     k, rsp_valid, rsp_data, eg, exp_d);
         end
         tick();
      end
      req_valid = 2'b00;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d;
      apply_reset();
      req_valid = 2'b10;
      for (int k = 0; k < 4; k++) begin
         a_r[1] = $urandom; b_r[1] = $urandom; op_r[1] = 4'($urandom);
         exp_d  = stub_alu(a_r[1], b_r[1], op_r[1]);
         #1;
         tests++;
         if (req_ready !== 2'b10 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle[%0d]: req_ready=%b busy=%b want 10 0", k, req_ready, busy);
         end
         tick();
         tests++;
         if (req_ready !== 2'b00 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_exec[%0d]: req_ready=%b busy=%b want 00 1", k, req_ready, busy);
         end
         tick();
         tests++;
         if (busy !== 1'b1 || rsp_valid !== 2'b10 || rsp_data !== exp_d) begin
            fails++;
            $display("FAIL b2b_rsp[%0d]: busy=%b rsp_valid=%b rsp_data=%h want 1 10 %h",
                     k, busy, rsp_valid, rsp_data, exp_d);
         end
         tick();
      end
      req_valid = 2'b00;
   endtask

   task automatic test_flags();
      apply_reset();
      a_r[0] = $urandom; b_r[0] = $urandom; op_r[0] = 4'($urandom);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      {stub_neg, stub_zero, stub_ovf} = 3'b101;
      tick();
      tests++;
      if (rsp_flags !== 3'b101 || rsp_valid !== 2'b01) begin
         fails++;
         $display("FAIL flags_rsp: rsp_flags=%b rsp_valid=%b want 101 01", rsp_flags, rsp_valid);
      end
      {stub_neg, stub_zero, stub_ovf} = 3'b010;
      for (int k = 0; k < 3; k++) begin
         tick();
         tests++;
         if (rsp_flags !== 3'b101) begin
            fails++; $display("FAIL flags_hold[%0d]: rsp_flags=%b want 101", k, rsp_flags);
         end
      end
   endtask

   task automatic test_reset_exec();
      apply_reset();
      a_r[0] = $urandom | 32'h1; b_r[0] = $urandom | 32'h1; op_r[0] = 4'h3;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      {stub_neg, stub_zero, stub_ovf} = 3'b111;
      tick();
      tick();
      {stub_neg, stub_zero, stub_ovf} = 3'b000;
      a_r[1] = $urandom | 32'h1; b_r[1] = $urandom | 32'h1; op_r[1] = 4'h9;
      req_valid = 2'b10;
      #1;
      tests++;
      if (req_ready !== 2'b10) begin
         fails++; $display("FAIL rstx_grant: req_ready=%b want 10", req_ready);
      end
      tick();   // now in EXEC for requester 1
      req_valid = 2'b00;
      n_rst     = 1'b0;
      tick();
      tests++;
      if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00 ||
          alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 4'h0 ||
          rsp_data !== 32'h0 || rsp_flags !== 3'b000) begin
         fails++;
         $display("FAIL rstx_clear: busy=%b rsp_valid=%b rdy=%b a=%h b=%h op=%h d=%h f=%b want all 0",
                  busy, rsp_valid, req_ready, alu_a, alu_b, alu_op, rsp_data, rsp_flags);
      end
      n_rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         tests++;
         if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rstx_no_rsp[%0d]: rsp_valid=%b busy=%b want 00 0", k, rsp_valid, busy);
         end
      end
      req_valid = 2'b11;
      #1;
      tests++;
      if (req_ready !== 2'b01) begin
         fails++; $display("FAIL rstx_regrant: req_ready=%b want 01", req_ready);
      end
      tick();
      req_valid = 2'b00;
      tick();
      tests++;
      if (rsp_valid !== 2'b01) begin
         fails++; $display("FAIL rstx_rsp: rsp_valid=%b want 01", rsp_valid);
      end
   endtask

   task automatic test_pulse_resp();
      logic [31:0] a0;
      apply_reset();
      a_r[0] = $urandom; b_r[0] = $urandom; op_r[0] = 4'($urandom);
      a_r[1] = ~a_r[0];  b_r[1] = $urandom; op_r[1] = 4'($urandom);
      a0 = a_r[0];
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();   // RESP
      req_valid = 2'b10;
      #1;
      tests++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b01) begin
         fails++;
         $display("FAIL pulse_in_resp: req_ready=%b rsp_valid=%b want 00 01", req_ready, rsp_valid);
      end
      tick();
      req_valid = 2'b00;
      #1;
      tests++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00 || alu_a !== a0) begin
         fails++;
         $display("FAIL pulse_after: rsp_valid=%b busy=%b req_ready=%b alu_a=%h want 00 0 00 %h",
                  rsp_valid, busy, req_ready, alu_a, a0);
      end
      tick();
      tests++;
      if (busy !== 1'b0 || alu_a !== a0) begin
         fails++; $display("FAIL pulse_no_grant: busy=%b alu_a=%h want 0 %h", busy, alu_a, a0);
      end
      req_valid = 2'b11;
      #1;
      tests++;
      if (req_ready !== 2'b10) begin
         fails++; $display("FAIL pulse_pointer: req_ready=%b want 10", req_ready);
      end
      tick();
      req_valid = 2'b00;
   endtask

   // Transaction-level model: a grant is possible whenever three cycles have
   // passed since the previous accept; the result appears two cycles after
   // the accept and stays until the next result.
   task automatic test_random(input int ncyc);
      int          acc, next_free, m_last, g_acc, win;
      logic [31:0] m_a, m_b, m_data;
      logic [3:0]  m_op;
      logic [2:0]  m_flags, exec_flags;
      logic [1:0]  v, exp_rdy, exp_rv;
      logic        exp_busy;
      apply_reset();
      acc = -10; next_free = 0; m_last = 1; g_acc = 0;
      m_a = '0; m_b = '0; m_op = '0; m_data = '0; m_flags = '0; exec_flags = '0;
      for (int c = 0; c < ncyc; c++) begin
         if (c > 0) tick();
         if (c == acc + 2) begin
            m_data  = stub_alu(m_a, m_b, m_op);
            m_flags = exec_flags;
         end
         exp_busy = (c > acc) && (c < next_free);
         exp_rv   = (c == acc + 2) ? ((g_acc == 0) ? 2'b01 : 2'b10) : 2'b00;
         tests++;
         if (busy !== exp_busy || rsp_valid !== exp_rv) begin
            fails++;
            $display("FAIL rnd_ctrl@%0d: busy=%b rsp_valid=%b want %b %b",
                     c, busy, rsp_valid, exp_busy, exp_rv);
         end
         tests++;
         if (rsp_data !== m_data || rsp_flags !== m_flags) begin
            fails++;
            $display("FAIL rnd_rsp@%0d: rsp_data=%h rsp_flags=%b want %h %b",
                     c, rsp_data, rsp_flags, m_data, m_flags);
         end
         tests++;
         if (alu_a !== m_a || alu_b !== m_b || alu_op !== m_op) begin
            fails++;
            $display("FAIL rnd_alu@%0d: a=%h b=%h op=%h want %h %h %h",
                     c, alu_a, alu_b, alu_op, m_a, m_b, m_op);
         end
         v = 2'($urandom_range(0, 3));
         for (int i = 0; i < 2; i++) begin
            a_r[i] = $urandom; b_r[i] = $urandom; op_r[i] = 4'($urandom);
         end
         {stub_neg, stub_zero, stub_ovf} = 3'($urandom);
         if (c == acc + 1) exec_flags = {stub_neg, stub_zero, stub_ovf};
         req_valid = v;
         #1;
         exp_rdy = 2'b00;
         if (c >= next_free && v != 2'b00) begin
            if (v == 2'b11) win = 1 - m_last;
            else            win = v[0] ? 0 : 1;
            exp_rdy   = (win == 0) ? 2'b01 : 2'b10;
            acc       = c;
            next_free = c + 3;
            m_last    = win;
            g_acc     = win;
            m_a       = a_r[win];
            m_b       = b_r[win];
            m_op      = op_r[win];
         end
         tests++;
         if (req_ready !== exp_rdy) begin
            fails++;
            $display("FAIL rnd_ready@%0d: req_valid=%b req_ready=%b want %b", c, v, req_ready, exp_rdy);
         end
      end
      req_valid = 2'b00;
   endtask

   initial begin
      n_rst     = 1'b0;
      req_valid = 2'b00;
      {stub_neg, stub_zero, stub_ovf} = 3'b000;
      for (int i = 0; i < 2; i++) begin
         a_r[i] = '0; b_r[i] = '0; op_r[i] = '0;
      end
      test_reset();
      test_single();
      test_alternate();
      test_back_to_back();
      test_flags();
      test_reset_exec();
      test_pulse_resp();
      test_random(400);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
